pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 SHALL have parameter SKID_EN, default 1; 1 = two-entry skid stage, 0 = single-entry stage.
REQ-003 SHALL have port CLK  input  1  rising-edge clock.
REQ-004 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  stage enable; 0 freezes the stage.
REQ-006 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-007 SHALL have port in_valid  input  1  upstream entry present.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  stage accepts this cycle.
REQ-010 SHALL have port out_valid  output  1  downstream entry present.
REQ-011 SHALL have port out_data  output  WIDTH  downstream payload.
REQ-012 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-013 SHALL have port occupancy  output  2  held-entry count, 0..2.
REQ-014 SHALL have port stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 SHALL implement states EMPTY (0 held), FULL (main held), SKID (main + skid held); SKID is unreachable when SKID_EN=0.
REQ-017 SHALL drive out_valid = en & ~flush & (state != EMPTY); out_data = main register.
REQ-018 SHALL drive in_ready = en & ~flush & (state != SKID) when SKID_EN=1; in_ready SHALL not depend combinationally on out_ready in this mode.
REQ-019 SHALL drive in_ready = en & ~flush & ((state == EMPTY) | out_ready) when SKID_EN=0.
REQ-020 EMPTY: in_fire -> FULL, main <= in_data; else hold.
REQ-021 FULL: in_fire & out_fire -> FULL, main <= in_data; in_fire only -> SKID, skid <= in_data; out_fire only -> EMPTY; neither -> hold.
REQ-022 SKID: out_fire -> FULL, main <= skid; else hold. Entries SHALL leave in arrival order.
REQ-023 Latency: an entry accepted in cycle N SHALL present on out_data in cycle N+1 when the stage was EMPTY or out_fire occurred in cycle N.
REQ-024 en=0: no transfer, state and data registers held; flush takes priority over en.
REQ-025 flush=1: next state EMPTY; in-cycle transfers suppressed (in_ready=out_valid=0); main and skid SHALL be cleared to 0.
REQ-026 occupancy SHALL equal 0/1/2 for EMPTY/FULL/SKID, reflecting the registered state (unaffected by en/flush gating within the cycle).
REQ-027 stall_cnt SHALL increment by 1 each cycle with out_valid & ~out_ready, saturate at 16'hFFFF, and be cleared only by reset.
REQ-028 Payload SHALL pass bit-exact; no entry duplicated or dropped except by flush.

Reset
REQ-029 nRST low SHALL asynchronously force state EMPTY, main=0, skid=0, stall_cnt=0.
REQ-030 While nRST low: in_ready=0, out_valid=0, out_data=0, occupancy=0.
REQ-031 Reset asserted mid-transfer SHALL discard all held entries; first accept is permitted on the first rising edge after nRST deasserts.

Structure
REQ-032 SHALL place the state enum (pipe_state_t: EMPTY, FULL, SKID) and STALL_CNT_W=16 in cpu_types_pkg.
REQ-033 SHALL be a single module with no sub-modules; the existing pipeline stages SHALL instantiate one per boundary, with payload packed into WIDTH.

Verification
REQ-034 Stream: SKID_EN=1, out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after accept, occupancy stays 1.
REQ-035 Backpressure: FULL holding 0xA, out_ready=0, push 0xB -> occupancy 2, in_ready=0 next cycle; release out_ready -> 0xA then 0xB, stall_cnt=number of stalled cycles.
REQ-036 Flush: SKID state holding 0xA,0xB, flush=1 one cycle with in_valid=1 data 0xC -> occupancy 0 next cycle, 0xC not captured, out_valid=0, out_data=0.
REQ-037 Freeze: FULL holding 0x5, en=0 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, in_ready=0, occupancy 1; en=1 -> 0x5 emitted.
REQ-038 SKID_EN=0: FULL, out_ready=0 -> in_ready=0 same cycle; out_ready=1 with in_valid=1 -> simultaneous replace, occupancy never 2.
REQ-039 Reset mid-op: SKID state, nRST low asynchronously between edges -> outputs zero immediately; stall_cnt saturation check after 65536 stalled cycles reads 0xFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: stage occupancy states and the stall counter width.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_skid_stage.sv
// Pipeline register stage with optional skid entry, en freeze, flush and stall counter.
// Latency: one cycle from accept to out_data when empty or draining in the same cycle.
// Backpressure: SKID_EN=1 registers in_ready (no out_ready path); SKID_EN=0 passes out_ready through.
module pipe_skid_stage
  import cpu_types_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  pipe_state_t      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             pass;
  logic             in_fire;
  logic             out_fire;

  assign pass      = en & ~flush;
  assign out_valid = pass & (state != EMPTY);
  assign out_data  = main_q;

  // nRST gating keeps in_ready low while the stage is held in reset.
  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = nRST & pass & (state != SKID);
    end else begin : g_single
      assign in_ready = nRST & pass & ((state == EMPTY) | out_ready);
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (en) begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= FULL;
            main_q <= in_data;
          end
        end
        FULL: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= SKID;
            skid_q <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        SKID: begin
          // Older entry sits in main, so promoting skid preserves arrival order.
          if (out_fire) begin
            state  <= FULL;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized and directed bench for pipe_skid_stage, both SKID_EN settings against a queue model.
module tb_pipe_skid_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready1, out_valid1, in_ready0, out_valid0;
  logic [31:0] out_data1, out_data0;
  logic [1:0]  occupancy1, occupancy0;
  logic [15:0] stall1, stall0;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: each stage is a FIFO of bounded depth; hold is the last main value when empty.
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] h1, h0;
  int          s1, s0;

  always #5 CLK = ~CLK;

  pipe_skid_stage #(.WIDTH(32), .SKID_EN(1'b1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready),
    .occupancy(occupancy1), .stall_cnt(stall1)
  );

  pipe_skid_stage #(.WIDTH(32), .SKID_EN(1'b0)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready),
    .occupancy(occupancy0), .stall_cnt(stall0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic e, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    en        = e;
    flush     = fl;
  endtask

  // Entered at posedge+1 with inputs driven; checks mid-cycle, then advances the model at the edge.
  task automatic cycle(input bit do_chk);
    logic r1, v1, r0, v0;
    #4;
    r1 = en & ~flush & (q1.size() < 2);
    v1 = en & ~flush & (q1.size() > 0);
    r0 = en & ~flush & ((q0.size() == 0) | out_ready);
    v0 = en & ~flush & (q0.size() > 0);
    if (do_chk) begin
      check("in_ready1",  in_ready1,  r1);
      check("out_valid1", out_valid1, v1);
      check("out_data1",  out_data1,  (q1.size() > 0) ? q1[0] : h1);
      check("occupancy1", occupancy1, q1.size());
      check("stall_cnt1", stall1,     s1);
      check("in_ready0",  in_ready0,  r0);
      check("out_valid0", out_valid0, v0);
      check("out_data0",  out_data0,  (q0.size() > 0) ? q0[0] : h0);
      check("occupancy0", occupancy0, q0.size());
      check("stall_cnt0", stall0,     s0);
    end
    @(posedge CLK);
    if (v1 && !out_ready && s1 < 65535) s1++;
    if (v0 && !out_ready && s0 < 65535) s0++;
    if (flush) begin
      q1.delete(); q0.delete(); h1 = '0; h0 = '0;
    end else begin
      if (v1 && out_ready) h1 = q1.pop_front();
      if (in_valid && r1) q1.push_back(in_data);
      if (v0 && out_ready) h0 = q0.pop_front();
      if (in_valid && r0) q0.push_back(in_data);
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready1"},  in_ready1,  '0);
    check({tag, "_out_valid1"}, out_valid1, '0);
    check({tag, "_out_data1"},  out_data1,  '0);
    check({tag, "_occupancy1"}, occupancy1, '0);
    check({tag, "_stall1"},     stall1,     '0);
    check({tag, "_in_ready0"},  in_ready0,  '0);
    check({tag, "_out_data0"},  out_data0,  '0);
  endtask

  // Asserts reset between edges and releases it at posedge+1, so the next edge may accept.
  task automatic apply_reset();
    #3;
    nRST = 1'b0;
    #1;
    check_zero("rst");
    q1.delete(); q0.delete();
    h1 = '0; h0 = '0; s1 = 0; s0 = 0;
    drive(1'b1, 32'h77, 1'b1, 1'b1, 1'b0);
    #1;
    check("rst_hold_in_ready1", in_ready1, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    apply_reset();

    // Back-to-back stream with a ready sink.
    drive(1'b1, 32'h11, 1'b1, 1'b1, 1'b0); cycle(1);
    check("stream_d0", out_data1, 32'h11);
    drive(1'b1, 32'h22, 1'b1, 1'b1, 1'b0); cycle(1);
    check("stream_d1", out_data1, 32'h22);
    check("stream_occ", occupancy1, 2'd1);
    drive(1'b1, 32'h33, 1'b1, 1'b1, 1'b0); cycle(1);
    check("stream_d2", out_data1, 32'h33);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0); cycle(1); cycle(1);

    // Backpressure into the skid entry, then drain in order.
    apply_reset();
    drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0); cycle(1);
    check("bp_single_rdy_low", in_ready0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0); cycle(1);
    check("bp_occ2", occupancy1, 2'd2);
    check("bp_in_ready", in_ready1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); cycle(1);
    check("bp_stall", stall1, 16'd2);
    drive(1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    #1;
    check("single_replace_rdy", in_ready0, 1'b1);
    check("bp_head", out_data1, 32'hA);
    cycle(1);
    check("bp_next", out_data1, 32'hB);
    check("single_replaced", out_data0, 32'hC);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0); cycle(1); cycle(1);

    // Flush while holding two entries.
    apply_reset();
    drive(1'b1, 32'hA, 1'b0, 1'b1, 1'b0); cycle(1);
    drive(1'b1, 32'hB, 1'b0, 1'b1, 1'b0); cycle(1);
    drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b1); cycle(1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #1;
    check("flush_occ", occupancy1, 2'd0);
    check("flush_vld", out_valid1, 1'b0);
    check("flush_dat", out_data1, 32'h0);
    cycle(1);

    // Freeze with en low.
    apply_reset();
    drive(1'b1, 32'h5, 1'b0, 1'b1, 1'b0); cycle(1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h9, 1'b1, 1'b0, 1'b0);
      #1;
      check("frz_vld", out_valid1, 1'b0);
      check("frz_rdy", in_ready1, 1'b0);
      check("frz_occ", occupancy1, 2'd1);
      cycle(1);
    end
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    #1;
    check("frz_release", out_data1, 32'h5);
    cycle(1);
    check("frz_drained", occupancy1, 2'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      drive($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 9) < 6,
            $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      cycle(1);
    end

    // Stall counter saturation.
    apply_reset();
    drive(1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0); cycle(1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (65540) cycle(0);
    cycle(1);
    check("sat_stall1", stall1, 16'hFFFF);
    check("sat_stall0", stall0, 16'hFFFF);

    // Reset arriving asynchronously while in the skid state.
    drive(1'b1, 32'h1, 1'b0, 1'b1, 1'b0); cycle(1);
    check("pre_rst_occ", occupancy1, 2'd2);
    apply_reset();
    drive(1'b1, 32'h42, 1'b1, 1'b1, 1'b0); cycle(1);
    check("post_rst_accept", out_data1, 32'h42);
    drive(1'b0, '0, 1'b1, 1'b1, 1'b0); cycle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
